count_watch: RTL and testbench

COUNT_WATCH -- requirements
Module: count_watch

---
 rtl/count_watch.sv | 179 +++++++++++++++++
 tb/tb_count_watch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_watch.sv
// count_watch: flags discontinuities in an upstream +1 counter and queues {prev, cur, stall}
// records in a fall-through FIFO. Optional drop counter enabled by COUNT_WATCH_DROP_CNT_EN.

package count_watch_pkg;

    typedef struct packed {
        logic [31:0] prev;
        logic [31:0] cur;
        logic        stall;
    } ev_rec_t;

endpackage

module count_watch
    import count_watch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              count,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [31:0]              ev_prev,
    output logic [31:0]              ev_cur,
    output logic                     ev_stall,
    output logic                     ovf,
    input  logic                     ovf_clr,
`ifdef COUNT_WATCH_DROP_CNT_EN
    output logic [15:0]              drop_cnt,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {
        S_PRIME = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_prev;
    logic            w_event;
    logic            w_stall;
    ev_rec_t         w_rec;

    ev_rec_t         r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_ovf;

    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_PRIME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and discontinuity detection; PRIME only loads the previous sample
    always_comb begin
        w_state_nxt = r_state;
        w_event     = 1'b0;
        case (r_state)
            S_PRIME: begin
                w_state_nxt = S_TRACK;
            end
            S_TRACK: begin
                w_event = (count != (r_prev + 32'd1));
            end
            default: begin
                w_state_nxt = S_PRIME;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev <= 32'd0;
        end else begin
            r_prev <= count;
        end
    end

    always_comb begin
        w_stall     = (count == r_prev);
        w_rec       = '0;
        w_rec.prev  = r_prev;
        w_rec.cur   = count;
        w_rec.stall = w_stall;
    end

    // FIFO control: a pop frees a slot for a same-cycle push; empty FIFO never bypasses
    always_comb begin
        w_full = (r_level == LW'(DEPTH));
        w_pop  = (r_level != LW'(0)) && ev_ready;
        w_push = w_event && (!w_full || w_pop);
        w_drop = w_event && w_full && !w_pop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky overflow; a drop on the same edge as a clear keeps it set
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef COUNT_WATCH_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_drop_cnt <= 16'd0;
        end else if (w_drop) begin
            if (ovf_clr) begin
                r_drop_cnt <= 16'd1;
            end else if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end else if (ovf_clr) begin
            r_drop_cnt <= 16'd0;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign ev_valid = (r_level != LW'(0));
    assign ev_prev  = r_mem[r_rd_ptr].prev;
    assign ev_cur   = r_mem[r_rd_ptr].cur;
    assign ev_stall = r_mem[r_rd_ptr].stall;
    assign ovf      = r_ovf;
    assign level    = r_level;

endmodule

// File: tb/tb_count_watch.sv
// Self-checking bench for count_watch: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.

module tb_count_watch;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [31:0] p;
        logic [31:0] c;
        logic        s;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] count;
    logic        ev_valid;
    logic        ev_ready;
    logic [31:0] ev_prev;
    logic [31:0] ev_cur;
    logic        ev_stall;
    logic        ovf;
    logic        ovf_clr;
    logic [2:0]  level;
`ifdef COUNT_WATCH_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    count_watch #(.DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .count    (count),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_prev  (ev_prev),
        .ev_cur   (ev_cur),
        .ev_stall (ev_stall),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
`ifdef COUNT_WATCH_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .level    (level)
    );

    always #5 clock = ~clock;

    int   n_pass  = 0;
    int   n_total = 0;
    bit   check_en = 1'b0;

    rec_t        m_q[$];
    logic [31:0] m_prev   = 32'd0;
    bit          m_primed = 1'b0;
    bit          m_ovf    = 1'b0;
    int          m_drops  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one clock edge given the inputs present at that edge
    task automatic model_edge(input logic [31:0] c, input logic rdy, input logic clr, input logic rst);
        bit   pop;
        bit   ev;
        bit   drop;
        rec_t r;
        if (rst) begin
            m_q.delete();
            m_primed = 1'b0;
            m_prev   = 32'd0;
            m_ovf    = 1'b0;
            m_drops  = 0;
            return;
        end
        pop  = (m_q.size() > 0) && rdy;
        ev   = m_primed && (c != m_prev + 32'd1);
        drop = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (ev) begin
            r.p = m_prev;
            r.c = c;
            r.s = (c == m_prev);
            if (m_q.size() < DEPTH) m_q.push_back(r);
            else drop = 1'b1;
        end
        if (drop) begin
            m_ovf = 1'b1;
            m_drops = clr ? 1 : ((m_drops < 65535) ? m_drops + 1 : 65535);
        end else if (clr) begin
            m_ovf = 1'b0;
            m_drops = 0;
        end
        m_prev   = c;
        m_primed = 1'b1;
    endtask

    // Continuous comparison against the model
    always @(negedge clock) begin
        if (check_en) begin
            chk("m_valid", 32'(ev_valid), 32'(m_q.size() != 0));
            chk("m_level", 32'(level), 32'(m_q.size()));
            chk("m_ovf", 32'(ovf), 32'(m_ovf));
`ifdef COUNT_WATCH_DROP_CNT_EN
            chk("m_drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
            if (m_q.size() != 0) begin
                chk("m_prev", ev_prev, m_q[0].p);
                chk("m_cur", ev_cur, m_q[0].c);
                chk("m_stall", 32'(ev_stall), 32'(m_q[0].s));
            end
        end
    end

    task automatic step(input logic [31:0] c, input logic rdy, input logic clr, input logic rst);
        count    = c;
        ev_ready = rdy;
        ovf_clr  = clr;
        reset    = rst;
        @(posedge clock);
        model_edge(c, rdy, clr, rst);
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        step(32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        count    = 32'd0;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        reset    = 1'b1;

        // Reset state
        do_reset();
        check_en = 1'b1;
        do_reset();
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_prev", ev_prev, 32'd0);
        chk("rst_cur", ev_cur, 32'd0);
        chk("rst_stall", 32'(ev_stall), 32'd0);

        // Clean increment 0..100
        for (int i = 0; i <= 100; i++) step(32'(i), 1'b0, 1'b0, 1'b0);
        chk("inc_valid", 32'(ev_valid), 32'd0);
        chk("inc_level", 32'(level), 32'd0);

        // Jump 11 -> 500
        do_reset();
        step(32'd10, 1'b1, 1'b0, 1'b0);
        step(32'd11, 1'b1, 1'b0, 1'b0);
        chk("jmp_pre_valid", 32'(ev_valid), 32'd0);
        step(32'd500, 1'b1, 1'b0, 1'b0);
        chk("jmp_valid", 32'(ev_valid), 32'd1);
        chk("jmp_prev", ev_prev, 32'd11);
        chk("jmp_cur", ev_cur, 32'd500);
        chk("jmp_stall", 32'(ev_stall), 32'd0);
        step(32'd501, 1'b1, 1'b0, 1'b0);
        chk("jmp_popped", 32'(ev_valid), 32'd0);

        // Stall 7,7,8 and held output while not ready
        do_reset();
        step(32'd7, 1'b0, 1'b0, 1'b0);
        step(32'd7, 1'b0, 1'b0, 1'b0);
        step(32'd8, 1'b0, 1'b0, 1'b0);
        step(32'd9, 1'b0, 1'b0, 1'b0);
        chk("stl_level", 32'(level), 32'd1);
        chk("stl_prev", ev_prev, 32'd7);
        chk("stl_cur", ev_cur, 32'd7);
        chk("stl_stall", 32'(ev_stall), 32'd1);
        step(32'd10, 1'b1, 1'b0, 1'b0);

        // Wrap is a normal increment
        do_reset();
        step(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        step(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        step(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        step(32'h0000_0001, 1'b0, 1'b0, 1'b0);
        chk("wrap_level", 32'(level), 32'd0);

        // Overflow: six jumps into a 4-deep FIFO, then drain in order
        do_reset();
        step(32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) step(32'(i * 10), 1'b0, 1'b0, 1'b0);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_flag", 32'(ovf), 32'd1);
`ifdef COUNT_WATCH_DROP_CNT_EN
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
        for (int i = 1; i <= 4; i++) begin
            chk("drain_cur", ev_cur, 32'(i * 10));
            step(32'(60 + i), 1'b1, 1'b0, 1'b0);
        end
        chk("drain_empty", 32'(ev_valid), 32'd0);
        step(32'd65, 1'b0, 1'b1, 1'b0);
        chk("ovf_clr", 32'(ovf), 32'd0);

        // Full FIFO: pop and push on the same edge
        do_reset();
        step(32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) step(32'(i * 10), 1'b0, 1'b0, 1'b0);
        step(32'd100, 1'b1, 1'b0, 1'b0);
        chk("fpp_level", 32'(level), 32'd4);
        chk("fpp_ovf", 32'(ovf), 32'd0);
        chk("fpp_head", ev_cur, 32'd20);
        step(32'd101, 1'b1, 1'b0, 1'b0);
        step(32'd102, 1'b1, 1'b0, 1'b0);
        step(32'd103, 1'b1, 1'b0, 1'b0);
        chk("fpp_tail_prev", ev_prev, 32'd40);
        chk("fpp_tail_cur", ev_cur, 32'd100);
        step(32'd104, 1'b1, 1'b0, 1'b0);

        // Drop coincides with ovf_clr: drop wins
        do_reset();
        step(32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) step(32'(i * 10), 1'b0, 1'b0, 1'b0);
        step(32'd50, 1'b0, 1'b1, 1'b0);
        chk("clr_drop_ovf", 32'(ovf), 32'd1);
`ifdef COUNT_WATCH_DROP_CNT_EN
        chk("clr_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

        // Reset mid-operation discards queue; next count only primes
        do_reset();
        step(32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) step(32'(i * 10), 1'b0, 1'b0, 1'b0);
        chk("mid_level_pre", 32'(level), 32'd3);
        do_reset();
        chk("mid_valid", 32'(ev_valid), 32'd0);
        chk("mid_level", 32'(level), 32'd0);
        step(32'd5, 1'b1, 1'b0, 1'b0);
        chk("mid_prime", 32'(ev_valid), 32'd0);
        // Ready on an empty FIFO with a same-cycle push: no bypass
        step(32'd50, 1'b1, 1'b0, 1'b0);
        chk("nobyp_level", 32'(level), 32'd1);
        chk("nobyp_cur", ev_cur, 32'd50);
        step(32'd51, 1'b1, 1'b0, 1'b0);
        chk("nobyp_pop", 32'(level), 32'd0);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
